// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default width and small op-decoding helpers.
package mdu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Pipeline-side bundle of the multiply/divide unit: request, operands, flush,
// and the stall/done/HI/LO results.
interface mdu_if #(parameter int DATA_W = mdu_pkg::DATA_W_DEF);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              flush;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output start, op, src_a, src_b, flush,
                    input  stall, done, hi, lo);
    modport slave  (input  start, op, src_a, src_b, flush,
                    output stall, done, hi, lo);
endinterface

// File: rtl/mdu_div_core.sv
// Unsigned restoring radix-2 divider, one quotient bit per step. The *_next
// outputs show the result of the step taken on the coming edge.
module mdu_div_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              last,
    output logic [DATA_W-1:0] quo_next,
    output logic [DATA_W-1:0] rem_next
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] rem_reg, quo_reg, dvs_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W:0]   rem_shift, diff;
    logic              fits;

    // Dividend bits shift out of the quotient register as quotient bits shift in.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[DATA_W-1]};
        diff      = rem_shift - {1'b0, dvs_reg};
        fits      = ~diff[DATA_W];
        rem_next  = fits ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
        quo_next  = {quo_reg[DATA_W-2:0], fits};
        last      = (cnt_reg == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg <= '0;
            quo_reg <= '0;
            dvs_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            rem_reg <= '0;
            quo_reg <= dividend;
            dvs_reg <= divisor;
            cnt_reg <= '0;
        end else if (step) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO with a stall/done handshake.
// Define MDU_DIV_EARLY_EN to finish trivial divisions (zero divisor, |a|<|b|) in one cycle.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MUL_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e              state_reg, state_next;
    logic                sgn_reg;
    logic [DATA_W-1:0]   a_reg, b_reg, hi_reg, lo_reg;
    logic [MC_W-1:0]     mul_cnt_reg;

    logic                accept, in_signed;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic                div_last, q_neg, r_neg;
    logic [DATA_W-1:0]   quo_next, rem_next, div_hi, div_lo;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_hi, wr_lo;

    // Operand magnitudes are taken straight from the bus so the divider loads on acceptance.
    always_comb begin
        accept    = (state_reg == IDLE) && bus.start && !bus.flush;
        in_signed = op_is_signed(bus.op);
        abs_a     = (in_signed && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
        abs_b     = (in_signed && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;
    end

    mdu_div_core #(.DATA_W(DATA_W)) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (state_reg == DIV),
        .dividend (abs_a),
        .divisor  (abs_b),
        .last     (div_last),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    // Sign fix-up: quotient negative iff signs differ, remainder follows the dividend.
    always_comb begin
        q_neg  = sgn_reg && (a_reg[DATA_W-1] ^ b_reg[DATA_W-1]);
        r_neg  = sgn_reg && a_reg[DATA_W-1];
        div_lo = (b_reg == '0) ? '1    : (q_neg ? -quo_next : quo_next);
        div_hi = (b_reg == '0) ? a_reg : (r_neg ? -rem_next : rem_next);
        a_ext  = {{DATA_W{sgn_reg & a_reg[DATA_W-1]}}, a_reg};
        b_ext  = {{DATA_W{sgn_reg & b_reg[DATA_W-1]}}, b_reg};
        prod   = a_ext * b_ext;
    end

    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        wr_hi      = '0;
        wr_lo      = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (op_is_div(bus.op)) begin
`ifdef MDU_DIV_EARLY_EN
                        if (abs_b == '0 || abs_a < abs_b) begin
                            state_next = DONE;
                            wr_en      = 1'b1;
                            wr_hi      = bus.src_a;
                            wr_lo      = (abs_b == '0) ? '1 : '0;
                        end else begin
                            state_next = DIV;
                        end
`else
                        state_next = DIV;
`endif
                    end else begin
                        state_next = MUL;
                    end
                end
            end
            MUL: begin
                if (mul_cnt_reg == MC_W'(MUL_LAT - 1)) begin
                    state_next     = DONE;
                    wr_en          = 1'b1;
                    {wr_hi, wr_lo} = prod;
                end
            end
            DIV: begin
                if (div_last) begin
                    state_next = DONE;
                    wr_en      = 1'b1;
                    wr_hi      = div_hi;
                    wr_lo      = div_lo;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
            wr_en      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            sgn_reg     <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            mul_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                sgn_reg <= in_signed;
                a_reg   <= bus.src_a;
                b_reg   <= bus.src_b;
            end
            if (state_reg == MUL) mul_cnt_reg <= mul_cnt_reg + 1'b1;
            else                  mul_cnt_reg <= '0;
            if (wr_en) begin
                hi_reg <= wr_hi;
                lo_reg <= wr_lo;
            end
        end
    end

    assign bus.stall = accept || (state_reg != IDLE);
    assign bus.done  = (state_reg == DONE);
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, flush/reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst;

    mdu_if #(.DATA_W(W)) bus ();

    mdu_unit #(.DATA_W(W), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        vecs [12];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] last_hi   = '0;
    logic [31:0] last_lo   = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    // Expected cycles from the start cycle to the done cycle.
    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_DIV_EARLY_EN
        logic [31:0] ma, mb;
        if (op[1]) begin
            ma = (op == OP_DIV && a[31]) ? -a : a;
            mb = (op == OP_DIV && b[31]) ? -b : b;
            if (b == 0 || ma < mb) return 1;
        end
`endif
        if (!op[1]) return MUL_LAT + 1;
        return W + 1;
    endfunction

    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            OP_MULTU: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = '1;
                end else if (op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = q; lo = p[31:0];
                    p = r; hi = p[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Issues one instruction in the next cycle and leaves start held through DONE.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        int lat      = 0;
        bit stall_ok = 1'b1;
        int want;
        want = exp_latency(op, a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        #1;
        if (bus.stall !== 1'b1) stall_ok = 1'b0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(negedge clk);
            #1;
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            if (bus.done === 1'b1) lat = k;
        end
        check({nm, ".latency"}, 64'(lat), 64'(want));
        check({nm, ".stall"}, 64'(stall_ok), 64'd1);
        check({nm, ".hi"}, 64'(bus.hi), 64'(ehi));
        check({nm, ".lo"}, 64'(bus.lo), 64'(elo));
        $display("%s op=%0d a=%h b=%h hi=%h lo=%h latency=%0d", nm, op, a, b, bus.hi, bus.lo, lat);
        last_hi = ehi;
        last_lo = elo;
    endtask

    task automatic release_and_check(input string nm);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check({nm, ".idle_done"}, 64'(bus.done), 64'd0);
        check({nm, ".idle_stall"}, 64'(bus.stall), 64'd0);
        check({nm, ".held_hi"}, 64'(bus.hi), 64'(last_hi));
        check({nm, ".held_lo"}, 64'(bus.lo), 64'(last_lo));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, rhi, rlo;
        bit          done_seen;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[6]  = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8]  = '{OP_DIV,   32'd5,        32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFF};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFF};
        vecs[10] = '{OP_DIVU,  32'd3,        32'd10,       32'h00000003, 32'h00000000};
        vecs[11] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset.stall", 64'(bus.stall), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;

        // Table runs back-to-back with start held through each DONE.
        for (int i = 0; i < 12; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
        release_and_check("vec_end");

        // Flush mid-division: no done, HI/LO untouched, then a fresh MULTU.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.src_a = 32'd100;
        bus.src_b = 32'd3;
        done_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        check("flush_div.stall", 64'(bus.stall), 64'd0);
        check("flush_div.done", 64'(bus.done | done_seen), 64'd0);
        check("flush_div.hi", 64'(bus.hi), 64'(last_hi));
        check("flush_div.lo", 64'(bus.lo), 64'(last_lo));
        $display("flush during DIV at T+10 stall=%0d done=%0d", bus.stall, bus.done);
        do_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "after_flush");
        release_and_check("after_flush_end");

        // Flush in the same cycle as start: the request is dropped.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_MULT;
        bus.src_a = 32'd7;
        bus.src_b = 32'd7;
        #1;
        check("flush_start.stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        done_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1 || bus.stall === 1'b1) done_seen = 1'b1;
        end
        check("flush_start.quiet", 64'(done_seen), 64'd0);
        check("flush_start.lo", 64'(bus.lo), 64'(last_lo));
        $display("flush with start lo=%h", bus.lo);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       ra = $urandom_range(0, 200);
                1:       ra = -$urandom_range(0, 200);
                2:       ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = -$urandom_range(1, 20);
                3:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            ref_model(rop, ra, rb, rhi, rlo);
            do_op(rop, ra, rb, rhi, rlo, $sformatf("rand%0d", i));
        end
        release_and_check("rand_end");

        // Reset in the middle of a division clears everything.
        do_op(OP_MULTU, 32'd5, 32'd7, 32'd0, 32'd35, "pre_reset");
        @(negedge clk);
        bus.op    = OP_DIVU;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd9;
        repeat (5) @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        check("rst_div.stall", 64'(bus.stall), 64'd0);
        check("rst_div.done", 64'(bus.done), 64'd0);
        check("rst_div.hi", 64'(bus.hi), 64'd0);
        check("rst_div.lo", 64'(bus.lo), 64'd0);
        $display("reset mid-DIV stall=%0d done=%0d hi=%h lo=%h", bus.stall, bus.done, bus.hi, bus.lo);
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
